fp32_to_int32: RTL and testbench
================================

Name: fp32_to_int32

Overview:
- Multi-cycle converter from IEEE754 single precision to signed 32-bit two's-complement integer.
- Sits directly downstream of the single-precision multiplier. Its ready input connects to the multiplier's done, and its op input to the multiplier's res.
- Uses the same one-shot ready/done handshake as the arithmetic units.
- Alignment is done with a serial shifter, one bit per cycle, then a round stage and a negate stage.

Parameters:
ROUND_NEAREST, 1, 1 = round to nearest, ties to even; 0 = truncate toward zero

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
ready  input  1  start strobe; sampled only in ST_IDLE
op  input  32  fp32 operand; captured on the edge where ready is sampled high
res  output  32  signed integer result; held until the next done
done  output  1  high for exactly one cycle when res is valid
invalid  output  1  NaN, Inf or out-of-range input; valid with done, held
inexact  output  1  nonzero fraction discarded; valid with done, held

Behaviour:
- Reset (asynchronous): state=ST_IDLE; res=0, done=0, invalid=0, inexact=0; internal registers cleared. Reset mid-conversion aborts the conversion with no done pulse.
- States: ST_IDLE, ST_DECODE, ST_SHIFT, ST_ROUND, ST_DONE.
- ST_IDLE:
  - done=0.
  - If ready=1: capture sign=op[31], e=op[30:23], m=op[22:0]; go to ST_DECODE.
  - Else stay.
- ST_DECODE: E = e-127, computed at 9-bit signed width. mag[31:0] = {8'b0, 1'b1, m}; guard=0; sticky=0. First matching case applies:
  - e=255, m!=0 (NaN): res=0x7FFFFFFF, invalid=1, inexact=0; go to ST_DONE.
  - e=255, m=0 (Inf): res=0x7FFFFFFF if sign=0, else 0x80000000; invalid=1; go to ST_DONE.
  - sign=1, e=158, m=0 (exactly -2^31): res=0x80000000, invalid=0, inexact=0; go to ST_DONE.
  - E>=31: saturate as for Inf; invalid=1; go to ST_DONE.
  - e=0 (zero or denormal): res=0, invalid=0, inexact=(m!=0); go to ST_DONE.
  - E<-1: res=0, inexact=1; go to ST_DONE.
  - 24<=E<=30: dir=left, cnt=E-23 (1..7); go to ST_SHIFT.
  - -1<=E<=22: dir=right, cnt=23-E (1..24); go to ST_SHIFT.
  - E=23: cnt=0; go to ST_ROUND.
- ST_SHIFT: one bit per cycle; cnt decrements every cycle.
  - Left: mag <= mag<<1.
  - Right: sticky <= sticky|guard; guard <= mag[0]; mag <= mag>>1.
  - Leave for ST_ROUND on the cycle cnt reaches 1.
- ST_ROUND:
  - inexact = guard|sticky.
  - If ROUND_NEAREST=1, increment mag when guard & (sticky | mag[0]). This increment cannot overflow: the maximum for E=30 is 2^31-128.
  - res = sign ? (~mag+1) : mag. A zero magnitude with sign=1 gives 0.
  - invalid=0; go to ST_DONE.
- ST_DONE: done=1 for exactly this cycle; next state ST_IDLE. ready is ignored in every state except ST_IDLE, so back-to-back strobes while busy are dropped.
- Latency from the ready-sampling edge to done high:
  - Special or early-exit cases: 2 cycles.
  - Normal: k+3 cycles, where k = cnt (0..24).
  - Worst case 27 cycles.
- res, invalid and inexact update only on the cycle done rises, and hold otherwise.
- Undefined state encodings return to ST_IDLE.

Test Plan:
- op=0x40490FDB (3.14159), RNE, k=22 -> res=0x00000003, inexact=1, invalid=0, done exactly 25 cycles after the ready edge, single-cycle pulse.
- Rounding:
  - 0x40600000 (3.5) -> RNE 4, truncate 3.
  - 0x3F000000 (0.5) -> 0 (tie to even), inexact=1.
  - 0x3F400000 (0.75) -> RNE 1.
  - 0xC0200000 (-2.5) -> RNE 0xFFFFFFFE, inexact=1.
- Range edges:
  - 0x4E800001 -> 0x40000080, exact, inexact=0.
  - 0xCF000000 -> 0x80000000, invalid=0.
  - 0x4F000000 -> 0x7FFFFFFF, invalid=1.
  - 0xD0000000 -> 0x80000000, invalid=1.
- Specials, latency 2:
  - 0x7FC00000 -> 0x7FFFFFFF, invalid=1.
  - 0xFF800000 -> 0x80000000, invalid=1.
  - 0x80000000 -> 0, flags 0.
  - 0x00000001 -> 0, inexact=1.
- Handshake: ready held high for 10 cycles during a conversion -> exactly one done; a new ready in the cycle after done starts a fresh conversion with correct result.
- Assert rst mid-ST_SHIFT on a 0x3F400000 conversion -> outputs 0 immediately, no done; a subsequent conversion of 0x41200000 (10.0) -> res=10, inexact=0.

Source files
------------

// File: rtl/fp32_to_int32.sv
// fp32_to_int32: multi-cycle IEEE754 single-precision to signed 32-bit
// integer converter. Alignment uses a one-bit-per-cycle serial shifter,
// followed by a round stage. Results are presented with a one-cycle done
// pulse and held until the next conversion completes.
module fp32_to_int32 #(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op,
  output logic [31:0] res,
  output logic        done,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [22:0] man_q, man_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [31:0] stgRes_q, stgRes_d;
  logic        stgInv_q, stgInv_d;
  logic        stgInx_q, stgInx_d;
  logic [31:0] res_q, res_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;
  logic        done_q, done_d;

  logic signed [8:0] expUnb;
  logic [4:0]        leftCnt;
  logic [4:0]        rightCnt;
  logic [31:0]       satRes;
  logic              roundUp;
  logic [31:0]       magRnd;

  // Unbiased exponent at 9-bit signed width so the range tests are plain
  // signed compares.
  assign expUnb = $signed({1'b0, exp_q}) - 9'sd127;

  // Shift counts only need five bits; 150 mod 32 = 22, so E-23 = e-150 and
  // 23-E = 150-e reduce to these 5-bit differences.
  assign leftCnt  = exp_q[4:0] - 5'd22;
  assign rightCnt = 5'd22 - exp_q[4:0];

  assign satRes  = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
  assign roundUp = ROUND_NEAREST && guard_q && (sticky_q || mag_q[0]);
  assign magRnd  = roundUp ? (mag_q + 32'd1) : mag_q;

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      exp_q     <= 8'd0;
      man_q     <= 23'd0;
      mag_q     <= 32'd0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= 5'd0;
      left_q    <= 1'b0;
      stgRes_q  <= 32'd0;
      stgInv_q  <= 1'b0;
      stgInx_q  <= 1'b0;
      res_q     <= 32'd0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      man_q     <= man_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      stgRes_q  <= stgRes_d;
      stgInv_q  <= stgInv_d;
      stgInx_q  <= stgInx_d;
      res_q     <= res_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: decode specials, shift serially, round, then publish
  // the staged result together with a single-cycle done pulse.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    man_d     = man_q;
    mag_d     = mag_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    stgRes_d  = stgRes_q;
    stgInv_d  = stgInv_q;
    stgInx_d  = stgInx_q;
    res_d     = res_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ready) begin
          sign_d  = op[31];
          exp_d   = op[30:23];
          man_d   = op[22:0];
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        mag_d    = {8'b0, 1'b1, man_q};
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        cnt_d    = 5'd0;
        left_d   = 1'b0;
        stgInv_d = 1'b0;
        stgInx_d = 1'b0;
        if ((&exp_q) && (|man_q)) begin
          stgRes_d = 32'h7FFF_FFFF;
          stgInv_d = 1'b1;
          state_d  = ST_DONE;
        end else if (&exp_q) begin
          stgRes_d = satRes;
          stgInv_d = 1'b1;
          state_d  = ST_DONE;
        end else if (sign_q && (exp_q == 8'd158) && (man_q == 23'd0)) begin
          stgRes_d = 32'h8000_0000;
          state_d  = ST_DONE;
        end else if (expUnb >= 9'sd31) begin
          stgRes_d = satRes;
          stgInv_d = 1'b1;
          state_d  = ST_DONE;
        end else if (exp_q == 8'd0) begin
          stgRes_d = 32'd0;
          stgInx_d = |man_q;
          state_d  = ST_DONE;
        end else if (expUnb < -9'sd1) begin
          stgRes_d = 32'd0;
          stgInx_d = 1'b1;
          state_d  = ST_DONE;
        end else if (expUnb >= 9'sd24) begin
          left_d  = 1'b1;
          cnt_d   = leftCnt;
          state_d = ST_SHIFT;
        end else if (expUnb <= 9'sd22) begin
          cnt_d   = rightCnt;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_SHIFT: begin
        cnt_d = cnt_q - 5'd1;
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          sticky_d = sticky_q | guard_q;
          guard_d  = mag_q[0];
          mag_d    = mag_q >> 1;
        end
        if (cnt_q == 5'd1) begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        stgInx_d = guard_q | sticky_q;
        stgInv_d = 1'b0;
        stgRes_d = sign_q ? (~magRnd + 32'd1) : magRnd;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        res_d     = stgRes_q;
        invalid_d = stgInv_q;
        inexact_d = stgInx_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign res     = res_q;
  assign done    = done_q;
  assign invalid = invalid_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_fp32_to_int32.sv
// tb_fp32_to_int32: directed-vector bench for the fp32 to int32 converter.
// Two instances are driven in parallel, one rounding to nearest-even and
// one truncating, against hand-computed expected results and latencies.
module tb_fp32_to_int32;

  logic        clk;
  logic        rst;
  logic        ready;
  logic [31:0] op;
  logic [31:0] resN, resT;
  logic        doneN, doneT;
  logic        invalidN, invalidT;
  logic        inexactN, inexactT;

  int checkCount;
  int failCount;

  fp32_to_int32 #(.ROUND_NEAREST(1'b1)) dutNearest (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .op      (op),
    .res     (resN),
    .done    (doneN),
    .invalid (invalidN),
    .inexact (inexactN)
  );

  fp32_to_int32 #(.ROUND_NEAREST(1'b0)) dutTrunc (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .op      (op),
    .res     (resT),
    .done    (doneT),
    .invalid (invalidT),
    .inexact (inexactT)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Strobe one operand, wait for done with a bounded budget, then check
  // results, flags, latency and that done is a single-cycle pulse.
  task automatic applyStimulus(input string name, input logic [31:0] opIn,
                               input logic [31:0] expNear,
                               input logic [31:0] expTrunc,
                               input logic expInv, input logic expInx,
                               input int expLat);
    int lat;
    @(negedge clk);
    op    = opIn;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    lat = 0;
    while (!doneN && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " done"}, {31'd0, doneN}, 32'd1);
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " res"}, resN, expNear);
    checkOutput({name, " invalid"}, {31'd0, invalidN}, {31'd0, expInv});
    checkOutput({name, " inexact"}, {31'd0, inexactN}, {31'd0, expInx});
    checkOutput({name, " trunc done"}, {31'd0, doneT}, 32'd1);
    checkOutput({name, " trunc res"}, resT, expTrunc);
    checkOutput({name, " trunc inexact"}, {31'd0, inexactT}, {31'd0, expInx});
    @(posedge clk);
    #1;
    checkOutput({name, " done pulse"}, {31'd0, doneN}, 32'd0);
    checkOutput({name, " res held"}, resN, expNear);
  endtask

  initial begin
    int doneCount;
    logic [31:0] seenRes;
    checkCount = 0;
    failCount  = 0;
    rst   = 1'b1;
    ready = 1'b0;
    op    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset res", resN, 32'd0);
    checkOutput("reset done", {31'd0, doneN}, 32'd0);
    checkOutput("reset invalid", {31'd0, invalidN}, 32'd0);
    checkOutput("reset inexact", {31'd0, inexactN}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("pi",        32'h40490FDB, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 25);
    applyStimulus("3.5",       32'h40600000, 32'h0000_0004, 32'h0000_0003, 1'b0, 1'b1, 25);
    applyStimulus("2.5",       32'h40200000, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b1, 25);
    applyStimulus("1.5",       32'h3FC00000, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1, 26);
    applyStimulus("0.5",       32'h3F000000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 27);
    applyStimulus("0.75",      32'h3F400000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 27);
    applyStimulus("-2.5",      32'hC0200000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b1, 25);
    applyStimulus("-10",       32'hC1200000, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, 1'b0, 23);
    applyStimulus("2^23+1",    32'h4B000001, 32'h0080_0001, 32'h0080_0001, 1'b0, 1'b0, 3);
    applyStimulus("2^30+128",  32'h4E800001, 32'h4000_0080, 32'h4000_0080, 1'b0, 1'b0, 10);
    applyStimulus("-2^31",     32'hCF000000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
    applyStimulus("2^31",      32'h4F000000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    applyStimulus("-2^33",     32'hD0000000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    applyStimulus("nan",       32'h7FC00000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    applyStimulus("-inf",      32'hFF800000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    applyStimulus("-0",        32'h80000000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    applyStimulus("denorm",    32'h00000001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2);
    applyStimulus("0.25",      32'h3E800000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2);

    // Hold ready high for ten cycles: only one conversion must complete.
    @(negedge clk);
    op        = 32'h40490FDB;
    ready     = 1'b1;
    doneCount = 0;
    seenRes   = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) ready = 1'b0;
      if (doneN) begin
        doneCount++;
        seenRes = resN;
      end
    end
    checkOutput("held ready done count", doneCount, 32'd1);
    checkOutput("held ready res", seenRes, 32'h0000_0003);

    // A fresh strobe right after a done pulse must start a new conversion.
    applyStimulus("10.0 a",    32'h41200000, 32'h0000_000A, 32'h0000_000A, 1'b0, 1'b0, 23);
    applyStimulus("b2b -10",   32'hC1200000, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, 1'b0, 23);

    // Reset in the middle of the serial shift aborts with no done pulse.
    @(negedge clk);
    op    = 32'h3F400000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort res", resN, 32'd0);
    checkOutput("abort done", {31'd0, doneN}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (doneN) doneCount++;
    end
    checkOutput("abort no done", doneCount, 32'd0);
    applyStimulus("10.0 after rst", 32'h41200000, 32'h0000_000A, 32'h0000_000A, 1'b0, 1'b0, 23);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
